// File: rtl/byp_ctrl_pkg.sv
// byp_ctrl_pkg: shared register-address parameters and the destination tuple carried down the pipe
package byp_ctrl_pkg;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] R0_IDX = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic we;
    logic ld;
  } dst_t;
  // R0 is hardwired zero, so it can never be a bypass source
  function automatic logic hit(input logic re, input dst_t t, input logic [ADDR_W-1:0] a);
    return re && t.we && (t.addr == a) && (a != R0_IDX);
  endfunction
endpackage

// File: rtl/byp_ctrl_dst_pipe_reg.sv
// dst_pipe_reg: destination tuple flop with stall-hold and clear-to-bubble
module dst_pipe_reg
  import byp_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic clr,
  input  dst_t d,
  output dst_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (!hold) q <= clr ? '0 : d;
endmodule

// File: rtl/byp_ctrl.sv
// byp_ctrl: bypass select generation, load-use interlock and WB write control for a 5-stage pipe
module byp_ctrl
  import byp_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              re0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] dst_addr_ID,
  input  logic              we_ID,
  input  logic              ld_ID,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              byp0_EX,
  output logic              byp0_DM,
  output logic              byp1_EX,
  output logic              byp1_DM,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_DM,
  output logic              stall_DM_WB,
  output logic [ADDR_W-1:0] rf_w_addr_DM_WB,
  output logic              rf_we_DM_WB
);
  dst_t id_t, ex_t, dm_t, wb_t;
  logic [1:0] hit_ex, hit_dm;
  logic lu, bubble, stall;
  // writes to R0 are dropped at the source so they never reach WB
  assign id_t = '{addr: dst_addr_ID, we: we_ID && (dst_addr_ID != R0_IDX), ld: ld_ID};
  assign hit_ex = {hit(re1, ex_t, p1_addr), hit(re0, ex_t, p0_addr)};
  assign hit_dm = {hit(re1, dm_t, p1_addr), hit(re0, dm_t, p0_addr)};
  assign lu = (|hit_ex) && ex_t.ld;
  assign bubble = flush || lu;
  assign stall = stall_ext && rst_n;
  assign stall_ID_EX = stall;
  assign stall_EX_DM = stall;
  assign stall_DM_WB = stall;
  assign stall_IF_ID = stall || (lu && !flush);
  assign rf_w_addr_DM_WB = wb_t.addr;
  assign rf_we_DM_WB = wb_t.we;
  dst_pipe_reg u_id_ex (.clk(clk), .rst_n(rst_n), .hold(stall), .clr(bubble), .d(id_t), .q(ex_t));
  dst_pipe_reg u_ex_dm (.clk(clk), .rst_n(rst_n), .hold(stall), .clr(1'b0), .d(ex_t), .q(dm_t));
  dst_pipe_reg u_dm_wb (.clk(clk), .rst_n(rst_n), .hold(stall), .clr(1'b0), .d(dm_t), .q(wb_t));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {byp0_EX, byp0_DM, byp1_EX, byp1_DM} <= '0;
    else if (!stall) {byp0_EX, byp0_DM, byp1_EX, byp1_DM} <= bubble ? '0 : {hit_ex[0], hit_dm[0], hit_ex[1], hit_dm[1]};
endmodule
